// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - PC redirect control: resolves EX redirects, holds them until the PC accepts, issues flushes (optional REDIRECT_STATS_EN)
module pc_redirect_ctrl #(
    parameter int WORD_W = 32,
    parameter int ADDR_W = 26
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              ihit,
    input  logic              stall,
    input  logic [WORD_W-1:0] pcaddr,
    input  logic              ex_valid,
    input  logic              ex_branch,
    input  logic              ex_bne,
    input  logic              ex_zero,
    input  logic              ex_jump,
    input  logic              ex_jr,
    input  logic              ex_halt,
    input  logic [WORD_W-1:0] ex_bimm,
    input  logic [ADDR_W-1:0] ex_jimm,
    input  logic [WORD_W-1:0] ex_rsdata,
    input  logic [WORD_W-1:0] ex_pc4,
    output logic              PCSrc,
    output logic              Jump,
    output logic              JR,
    output logic              PC_EN,
    output logic [WORD_W-1:0] bimm,
    output logic [ADDR_W-1:0] jimm,
    output logic [WORD_W-1:0] jraddr,
    output logic [WORD_W-1:0] branch_pc,
    output logic              iREN,
    output logic [WORD_W-1:0] iaddr,
    output logic              flush,
`ifdef REDIRECT_STATS_EN
    output logic [31:0]       redirect_cnt,
    output logic [31:0]       pend_cycles,
`endif
    output logic              halted
);

    typedef enum logic [1:0] {RUN, PEND, HALT} state_t;

    state_t              state;
    logic                p_pcsrc;
    logic                p_jump;
    logic                p_jr;
    logic [WORD_W-1:0]   p_bimm;
    logic [ADDR_W-1:0]   p_jimm;
    logic [WORD_W-1:0]   p_jraddr;
    logic [WORD_W-1:0]   p_branch_pc;

    logic                accept;
    logic                halt_req;
    logic                taken;
    logic                d_pcsrc;
    logic                d_jump;
    logic                d_jr;

    // Handshake and EX redirect decode; halt suppresses any redirect in the same cycle
    always_comb begin
        accept   = ihit & ~stall & (state != HALT);
        halt_req = ex_valid & ex_halt & (state != HALT);
        d_jr     = ex_jr;
        d_jump   = ~ex_jr & ex_jump;
        d_pcsrc  = ~ex_jr & ~ex_jump & ex_branch & (ex_bne ^ ex_zero);
        taken    = (state == RUN) & ex_valid & ~ex_halt & (d_jr | d_jump | d_pcsrc);
    end

    // PC control outputs: live EX redirect in RUN, replayed pending redirect in PEND
    always_comb begin
        PCSrc     = 1'b0;
        Jump      = 1'b0;
        JR        = 1'b0;
        PC_EN     = 1'b0;
        bimm      = '0;
        jimm      = '0;
        jraddr    = '0;
        branch_pc = '0;
        flush     = 1'b0;
        iaddr     = pcaddr;
        iREN      = RST | (state != HALT);
        halted    = ~RST & (state == HALT);
        if (!RST) begin
            PC_EN = accept;
            if (taken) begin
                PCSrc     = d_pcsrc;
                Jump      = d_jump;
                JR        = d_jr;
                bimm      = ex_bimm;
                jimm      = ex_jimm;
                jraddr    = ex_rsdata;
                branch_pc = ex_pc4;
                flush     = accept;
            end else if (state == PEND && !halt_req) begin
                PCSrc     = p_pcsrc;
                Jump      = p_jump;
                JR        = p_jr;
                bimm      = p_bimm;
                jimm      = p_jimm;
                jraddr    = p_jraddr;
                branch_pc = p_branch_pc;
                flush     = accept;
            end
        end
    end

    // State machine and pending-redirect holding registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= RUN;
            p_pcsrc     <= 1'b0;
            p_jump      <= 1'b0;
            p_jr        <= 1'b0;
            p_bimm      <= '0;
            p_jimm      <= '0;
            p_jraddr    <= '0;
            p_branch_pc <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (halt_req) begin
                        state <= HALT;
                    end else if (taken && !accept) begin
                        state       <= PEND;
                        p_pcsrc     <= d_pcsrc;
                        p_jump      <= d_jump;
                        p_jr        <= d_jr;
                        p_bimm      <= ex_bimm;
                        p_jimm      <= ex_jimm;
                        p_jraddr    <= ex_rsdata;
                        p_branch_pc <= ex_pc4;
                    end
                end
                PEND: begin
                    if (halt_req || accept) begin
                        state       <= halt_req ? HALT : RUN;
                        p_pcsrc     <= 1'b0;
                        p_jump      <= 1'b0;
                        p_jr        <= 1'b0;
                        p_bimm      <= '0;
                        p_jimm      <= '0;
                        p_jraddr    <= '0;
                        p_branch_pc <= '0;
                    end
                end
                default: state <= HALT;
            endcase
        end
    end

`ifdef REDIRECT_STATS_EN
    // Redirect and pending-cycle counters; both idle in HALT since neither event occurs there
    always_ff @(posedge CLK) begin
        if (RST) begin
            redirect_cnt <= '0;
            pend_cycles  <= '0;
        end else begin
            if (flush)
                redirect_cnt <= redirect_cnt + 32'd1;
            if (state == PEND)
                pend_cycles <= pend_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: doc/pc_redirect_ctrl.md
Name: pc_redirect_ctrl

Overview:
- Drives the program counter control interface (PCSrc, Jump, JR, PC_EN, bimm, jimm, jraddr, branch_pc) from EX-stage branch/jump resolution and the instruction-fetch handshake.
- Holds a resolved redirect whenever the PC cannot advance, replays it until the PC accepts it, and issues one-cycle pipeline flushes.
- Consumes pcaddr to track the fetch address and gates iREN. Sits between the EX stage, the hazard unit and the program counter.

Parameters:
- WORD_W, 32, data/address word width (word_t)
- ADDR_W, 26, jump-target field width (jimm)

Ports:
- CLK  input  1  clock
- RST  input  1  synchronous active-high reset
- ihit  input  1  instruction memory returned instruction this cycle
- stall  input  1  hazard-unit stall request
- pcaddr  input  WORD_W  current PC from program counter
- ex_valid  input  1  EX-stage instruction is valid
- ex_branch  input  1  EX instruction is a conditional branch
- ex_bne  input  1  1 = BNE, 0 = BEQ
- ex_zero  input  1  ALU zero flag
- ex_jump  input  1  J/JAL
- ex_jr  input  1  JR
- ex_halt  input  1  HALT in EX
- ex_bimm  input  WORD_W  sign-extended, pre-shifted branch offset
- ex_jimm  input  ADDR_W  jump target field
- ex_rsdata  input  WORD_W  forwarded rs value
- ex_pc4  input  WORD_W  EX instruction PC+4
- PCSrc  output  1  select branch target
- Jump  output  1  select jump target
- JR  output  1  select register target
- PC_EN  output  1  PC update enable
- bimm  output  WORD_W  branch offset
- jimm  output  ADDR_W  jump field
- jraddr  output  WORD_W  register target
- branch_pc  output  WORD_W  base for branch target
- iREN  output  1  instruction read enable
- iaddr  output  WORD_W  instruction address (= pcaddr)
- flush  output  1  one-cycle IF/ID + ID/EX flush
- halted  output  1  sticky halt indicator

Behaviour:
- Single clock CLK; RST synchronous, active-high. On RST: state=RUN, pending regs cleared, all outputs 0 except iREN=1; iaddr follows pcaddr.
- States: RUN, PEND, HALT.
- accept = ihit & ~stall & (state != HALT). PC_EN = accept, combinational.
- Redirect decode in RUN, when ex_valid: taken = ex_jr | ex_jump | (ex_branch & (ex_bne ^ ex_zero)).
- Priority when several are set: JR > Jump > PCSrc. Exactly one select is asserted.
- RUN, taken, accept=1: select and operand outputs driven combinationally from ex_* this cycle; flush=1 for this cycle; remain RUN.
- RUN, taken, accept=0: latch select and operands into pending regs; go to PEND. Outputs are driven from ex_* this cycle as well, but no flush.
- PEND: outputs driven from pending regs; ex_* ignored.
  - On first cycle with accept=1: flush=1, pending regs clear next edge, return to RUN.
- Not taken: PCSrc=Jump=JR=0; operand outputs = 0.
- ex_valid & ex_halt (RUN or PEND) -> HALT next edge. Halt wins over a simultaneous redirect; pending is discarded.
- HALT: PC_EN=0, iREN=0, halted=1, flush=0. Sticky until RST.
- flush is never asserted for more than one consecutive cycle per redirect.
- RST mid-PEND or mid-HALT: pending dropped, back to RUN next edge.
- Widths: no arithmetic in this block. Operands are passed through unmodified at full width.

Optional Feature:
- Macro REDIRECT_STATS_EN.
- When defined: adds output ports redirect_cnt[31:0] and pend_cycles[31:0], both reset to 0.
  - redirect_cnt increments on each flush pulse.
  - pend_cycles increments each cycle in PEND.
  - Both wrap at 2^32 and freeze in HALT.
- When not defined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- BEQ taken with immediate accept: ex_branch=1, ex_bne=0, ex_zero=1, ex_pc4=0x104, ex_bimm=0x20, ihit=1 -> same cycle PCSrc=1, branch_pc=0x104, bimm=0x20, PC_EN=1, flush=1; next cycle flush=0.
- BNE not taken: ex_bne=1, ex_zero=1 -> PCSrc=Jump=JR=0, flush=0, PC_EN=ihit.
- JR during fetch stall: ex_jr=1, ex_rsdata=0x400, ihit=0 for 3 cycles then 1 -> PEND for 3 cycles, JR=1 and jraddr=0x400 held throughout with ex_* changed to junk; flush=1 only on the ihit cycle; then RUN.
- Priority: ex_jump=1 with ex_jr=1 and branch taken, ex_rsdata=0x80 -> JR=1 only, jraddr=0x80.
- Halt over redirect: ex_halt=1 with ex_jump=1 -> next cycle halted=1, PC_EN=0, iREN=0 regardless of ihit. RST=1 for one edge -> RUN, iREN=1, halted=0.
- With REDIRECT_STATS_EN: 2 immediate redirects plus one redirect stalled 4 cycles -> redirect_cnt=3, pend_cycles=4.
